bin2bcd_seq: RTL and testbench

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_seq.sv | 97 +++++++++
 tb/tb_bin2bcd_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// bin2bcd_seq : sequential 7-bit binary to 2-digit packed BCD (double dabble)
// Rev 1.0
// ============================================================================
module bin2bcd_seq #(
  parameter int SATURATE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] bin,
  output logic       busy,
  output logic       done,
  output logic [7:0] q,
  output logic       ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] c_ITER = 3'd7;
  localparam logic [7:0] c_SAT  = 8'h99;

  state_t      r_state;
  logic [6:0]  r_bin;
  logic [11:0] r_bcd;
  logic [2:0]  r_cnt;

  logic [11:0] w_adj;
  logic        w_ovf;
  logic [7:0]  w_q;

  always_comb begin
    for (int d = 0; d < 3; d++) begin
      w_adj[d*4 +: 4] = (r_bcd[d*4 +: 4] >= 4'd5) ? r_bcd[d*4 +: 4] + 4'd3
                                                   : r_bcd[d*4 +: 4];
    end
  end

  // Hundreds digit is at most 1 for a 7-bit input, so any nonzero value means >99.
  assign w_ovf = |r_bcd[11:8];
  assign w_q   = (w_ovf && (SATURATE != 0)) ? c_SAT : r_bcd[7:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_bin   <= 7'd0;
      r_bcd   <= 12'd0;
      r_cnt   <= 3'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      q       <= 8'h00;
      ovf     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_bin   <= bin;
            r_bcd   <= 12'd0;
            r_cnt   <= c_ITER;
            busy    <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (r_cnt != 3'd0) begin
            r_bcd <= {w_adj[10:0], r_bin[6]};
            r_bin <= {r_bin[5:0], 1'b0};
            r_cnt <= r_cnt - 3'd1;
          end else begin
            q       <= w_q;
            ovf     <= w_ovf;
            done    <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// tb_bin2bcd_seq : scoreboard bench driving SATURATE=1 and SATURATE=0 copies
// Rev 1.0
// ============================================================================
module tb_bin2bcd_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [6:0] bin;
  logic       busy_s, done_s, ovf_s;
  logic [7:0] q_s;
  logic       busy_r, done_r, ovf_r;
  logic [7:0] q_r;
  logic [7:0] w_xs3;

  int errors = 0;
  int checks = 0;
  logic prev_done_s = 1'b0;
  logic prev_done_r = 1'b0;
  logic [8:0] sb_sat[$];
  logic [8:0] sb_raw[$];

  typedef struct {
    logic [6:0] bin;
    logic [7:0] q_sat;
    logic [7:0] q_raw;
    logic       ovf;
  } vec_t;
  vec_t vecs[10];

  always #5 clk = ~clk;

  bin2bcd_seq #(.SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy_s), .done(done_s), .q(q_s), .ovf(ovf_s)
  );
  bin2bcd_seq #(.SATURATE(0)) u_raw (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy_r), .done(done_r), .q(q_r), .ovf(ovf_r)
  );

  // Downstream excess-3 stage fed straight from q.
  assign w_xs3 = {q_s[7:4] + 4'd3, q_s[3:0] + 4'd3};

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [8:0] model(input int v, input bit sat);
    if (v > 99) return sat ? {1'b1, 8'h99} : {1'b1, to_bcd(v - 100)};
    return {1'b0, to_bcd(v)};
  endfunction

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic on_done(input string tag, input logic prev, input logic [7:0] qv,
                         input logic ov, inout logic [8:0] sb[$]);
    logic [8:0] e;
    check({tag, "_done_width"}, {8'd0, prev}, 9'd0);
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_unexpected_done: got q=%h ovf=%b expected no done", tag, qv, ov);
    end else begin
      e = sb.pop_front();
      check({tag, "_result"}, {ov, qv}, e);
    end
    check({tag, "_bcd_legal"}, {7'd0, qv[7:4] > 4'd9, qv[3:0] > 4'd9}, 9'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (done_s) on_done("sat", prev_done_s, q_s, ovf_s, sb_sat);
    if (done_r) on_done("raw", prev_done_r, q_r, ovf_r, sb_raw);
    prev_done_s = done_s;
    prev_done_r = done_r;
  endtask

  task automatic start_conv(input int v, input bit push,
                            input logic [8:0] es = 9'h1FF, input logic [8:0] er = 9'h1FF);
    int n = 0;
    while (busy_s && n < 40) begin
      tick();
      n++;
    end
    if (busy_s) begin
      errors++;
      $display("FAIL busy_timeout: got busy=1 expected 0 within 40 cycles");
    end
    start = 1'b1;
    bin   = 7'(v);
    if (push) begin
      sb_sat.push_back(es === 9'h1FF ? model(v, 1'b1) : es);
      sb_raw.push_back(er === 9'h1FF ? model(v, 1'b0) : er);
    end
    tick();
    start = 1'b0;
    bin   = 7'($urandom_range(0, 127));
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_sat.size() != 0 || sb_raw.size() != 0) && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (sb_sat.size() != 0 || sb_raw.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb_sat.size() + sb_raw.size());
      sb_sat.delete();
      sb_raw.delete();
    end
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int lat;
    vecs[0] = '{7'd0,   8'h00, 8'h00, 1'b0};
    vecs[1] = '{7'd45,  8'h45, 8'h45, 1'b0};
    vecs[2] = '{7'd99,  8'h99, 8'h99, 1'b0};
    vecs[3] = '{7'd100, 8'h99, 8'h00, 1'b1};
    vecs[4] = '{7'd127, 8'h99, 8'h27, 1'b1};
    vecs[5] = '{7'd58,  8'h58, 8'h58, 1'b0};
    vecs[6] = '{7'd7,   8'h07, 8'h07, 1'b0};
    vecs[7] = '{7'd10,  8'h10, 8'h10, 1'b0};
    vecs[8] = '{7'd64,  8'h64, 8'h64, 1'b0};
    vecs[9] = '{7'd115, 8'h99, 8'h15, 1'b1};

    rst = 1'b1; start = 1'b0; bin = 7'd0;
    idle_ticks(2);
    check("reset_sat", {busy_s, done_s, ovf_s, 6'd0} | {1'b0, q_s}, 9'd0);
    check("reset_raw", {busy_r, done_r, ovf_r, 6'd0} | {1'b0, q_r}, 9'd0);
    rst = 1'b0;
    tick();

    // Latency: done appears 8 edges after the accepting edge.
    start_conv(0, 1'b1);
    check("busy_after_start", {8'd0, busy_s}, 9'd1);
    lat = 0;
    while (!done_s && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", 9'(lat), 9'd8);
    check("busy_with_done", {8'd0, busy_s}, 9'd1);
    tick();
    check("busy_after_done", {7'd0, busy_s, done_s}, 9'd0);

    for (int i = 0; i < 10; i++) begin
      start_conv(int'(vecs[i].bin), 1'b1, {vecs[i].ovf, vecs[i].q_sat}, {vecs[i].ovf, vecs[i].q_raw});
      drain();
    end

    for (int v = 0; v < 100; v++) start_conv(v, 1'b1);
    drain();

    // Second start while busy is dropped.
    start_conv(12, 1'b1);
    idle_ticks(2);
    start = 1'b1; bin = 7'd88;
    tick();
    start = 1'b0;
    drain();
    idle_ticks(12);
    check("ignored_start_q", {1'b0, q_s}, 9'h012);

    // Reset on the 4th shift edge aborts the conversion.
    start_conv(73, 1'b0);
    idle_ticks(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_state", {busy_s, done_s, 7'd0}, 9'd0);
    check("abort_q", {ovf_s, q_s}, 9'd0);
    idle_ticks(12);
    start_conv(73, 1'b1);
    drain();
    check("restart_q", {1'b0, q_s}, 9'h073);

    start_conv(58, 1'b1);
    drain();
    check("xs3_chain", {1'b0, w_xs3}, 9'h08B);

    // Reset wins over start on the same edge.
    rst = 1'b1; start = 1'b1; bin = 7'd33;
    tick();
    rst = 1'b0; start = 1'b0;
    check("rst_priority", {7'd0, busy_s, busy_r}, 9'd0);
    idle_ticks(12);

    check("sb_empty", 9'(sb_sat.size() + sb_raw.size()), 9'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
